// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding and light constants
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5,
    NIGHT_BLINK = 3'd6
  } phase_e;

  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable tick down-counter for phase durations
module phase_timer #(
  parameter int              CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             etick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] timer,
  output logic             zero
);

  // A load always takes priority: it happens on the same tick that ends a phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= RST_VAL;
    end else if (load) begin
      timer <= load_val;
    end else if (etick && (timer != '0)) begin
      timer <= timer - 1'b1;
    end
  end

  assign zero = (timer == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - intersection phase sequencer with pedestrian and night modes
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int T_GREEN_MAIN = 20,
  parameter int T_MIN_GREEN  = 5,
  parameter int T_GREEN_SIDE = 10,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 2,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       night_mode,
  input  logic       ped_req,
  output logic [2:0] main_ryg,
  output logic [2:0] side_ryg,
  output logic       ped_walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] LD_GREEN_MAIN = CNT_W'(T_GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] LD_GREEN_SIDE = CNT_W'(T_GREEN_SIDE - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_ALL_RED    = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] EARLY_LIMIT   = CNT_W'(T_GREEN_MAIN - T_MIN_GREEN);

  phase_e             state, state_nxt;
  logic               etick;
  logic               load;
  logic [CNT_W-1:0]   load_val;
  logic [CNT_W-1:0]   timer;
  logic               zero;
  logic               ped_pending;
  logic               served;
  logic               blink;
  logic               serve;

  assign etick = tick & enable;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_ALL_RED)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .etick    (etick),
    .load     (load),
    .load_val (load_val),
    .timer    (timer),
    .zero     (zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ALL_RED_2;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = '0;
    case (state)
      MAIN_GREEN: begin
        if (etick && (zero || (ped_pending && (timer <= EARLY_LIMIT)))) begin
          state_nxt = MAIN_YELLOW;
          load      = 1'b1;
          load_val  = LD_YELLOW;
        end
      end
      MAIN_YELLOW: begin
        if (etick && zero) begin
          state_nxt = ALL_RED_1;
          load      = 1'b1;
          load_val  = LD_ALL_RED;
        end
      end
      ALL_RED_1: begin
        if (etick && zero) begin
          if (night_mode) begin
            state_nxt = NIGHT_BLINK;
          end else begin
            state_nxt = SIDE_GREEN;
            load      = 1'b1;
            load_val  = LD_GREEN_SIDE;
          end
        end
      end
      SIDE_GREEN: begin
        if (etick && zero) begin
          state_nxt = SIDE_YELLOW;
          load      = 1'b1;
          load_val  = LD_YELLOW;
        end
      end
      SIDE_YELLOW: begin
        if (etick && zero) begin
          state_nxt = ALL_RED_2;
          load      = 1'b1;
          load_val  = LD_ALL_RED;
        end
      end
      ALL_RED_2: begin
        if (etick && zero) begin
          if (night_mode) begin
            state_nxt = NIGHT_BLINK;
          end else begin
            state_nxt = MAIN_GREEN;
            load      = 1'b1;
            load_val  = LD_GREEN_MAIN;
          end
        end
      end
      NIGHT_BLINK: begin
        if (etick && !night_mode) begin
          state_nxt = ALL_RED_2;
          load      = 1'b1;
          load_val  = LD_ALL_RED;
        end
      end
      default: begin
        state_nxt = ALL_RED_2;
        load      = 1'b1;
        load_val  = LD_ALL_RED;
      end
    endcase
  end

  // Serving the request and clearing pending share one edge, so a coincident ped_req is dropped.
  assign serve = (state != SIDE_GREEN) && (state_nxt == SIDE_GREEN) && ped_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
      served      <= 1'b0;
      ped_ack     <= 1'b0;
      blink       <= 1'b0;
    end else begin
      ped_ack <= serve;
      if (serve)        ped_pending <= 1'b0;
      else if (ped_req) ped_pending <= 1'b1;
      if (serve)                                                served <= 1'b1;
      else if ((state == SIDE_GREEN) && (state_nxt != SIDE_GREEN)) served <= 1'b0;
      if (state != NIGHT_BLINK) blink <= 1'b0;
      else if (etick)           blink <= night_mode ? ~blink : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_ryg <= LT_RED;
      side_ryg <= LT_RED;
      ped_walk <= 1'b0;
    end else begin
      ped_walk <= served && (state == SIDE_GREEN);
      case (state)
        MAIN_GREEN:  begin main_ryg <= LT_GRN; side_ryg <= LT_RED; end
        MAIN_YELLOW: begin main_ryg <= LT_YEL; side_ryg <= LT_RED; end
        SIDE_GREEN:  begin main_ryg <= LT_RED; side_ryg <= LT_GRN; end
        SIDE_YELLOW: begin main_ryg <= LT_RED; side_ryg <= LT_YEL; end
        NIGHT_BLINK: begin
          main_ryg <= blink ? LT_YEL : LT_OFF;
          side_ryg <= blink ? LT_YEL : LT_OFF;
        end
        default:     begin main_ryg <= LT_RED; side_ryg <= LT_RED; end
      endcase
    end
  end

  assign phase = state;

endmodule
